// File: rtl/hack_rom_loader.sv
// Program ROM for the Hack CPU: filled from a valid/ready word stream, combinational fetch port, CPU reset sequencing.
// Fetch has zero latency; load_ready rises one cycle after entering LOAD and drops on the final accepted word.
module hack_rom_loader #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       pc,
  output logic [DATA_W-1:0] instruction,
  output logic              cpu_reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic [ADDR_W:0]   prog_len,
  output logic              overflow,
  output logic              fetch_oob
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CMP_W = (ADDR_W + 1 > 16) ? ADDR_W + 1 : 16;
  localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RELEASE, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic              overflow_q, overflow_d;
  logic              fetch_oob_q, fetch_oob_d;
  logic              load_ready_q, load_ready_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic xfer;
  logic xfer_end;
  logic pc_oob;

  assign xfer     = (state_q == S_LOAD) && load_valid && load_ready_q;
  // The word written into the top slot always ends the load, marked last or not.
  assign xfer_end = xfer && (load_last || (wptr_q == LAST_SLOT));
  assign pc_oob   = CMP_W'(pc) >= CMP_W'(prog_len_q);

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    prog_len_d   = prog_len_q;
    overflow_d   = overflow_q;
    fetch_oob_d  = fetch_oob_q;
    load_ready_d = load_ready_q;
    unique case (state_q)
      S_IDLE: begin
        load_ready_d = 1'b0;
        if (load_start) begin
          state_d     = S_LOAD;
          wptr_d      = '0;
          prog_len_d  = '0;
          overflow_d  = 1'b0;
          fetch_oob_d = 1'b0;
        end
      end
      S_LOAD: begin
        load_ready_d = 1'b1;
        if (xfer) wptr_d = wptr_q + 1'b1;
        if (xfer_end) begin
          prog_len_d   = wptr_q + 1'b1;
          overflow_d   = !load_last;
          load_ready_d = 1'b0;
          state_d      = S_RELEASE;
        end
      end
      S_RELEASE: begin
        load_ready_d = 1'b0;
        state_d      = S_RUN;
      end
      S_RUN: begin
        load_ready_d = 1'b0;
        if (pc_oob) fetch_oob_d = 1'b1;
        // A reload wins over a simultaneous out-of-range fetch.
        if (load_start) begin
          state_d     = S_LOAD;
          wptr_d      = '0;
          prog_len_d  = '0;
          overflow_d  = 1'b0;
          fetch_oob_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      wptr_q       <= '0;
      prog_len_q   <= '0;
      overflow_q   <= 1'b0;
      fetch_oob_q  <= 1'b0;
      load_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      prog_len_q   <= prog_len_d;
      overflow_q   <= overflow_d;
      fetch_oob_q  <= fetch_oob_d;
      load_ready_q <= load_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) mem_q[wptr_q[ADDR_W-1:0]] <= load_data;
  end

  assign instruction = ((state_q == S_RUN) && !pc_oob) ? mem_q[pc[ADDR_W-1:0]] : '0;
  assign cpu_reset   = (state_q != S_RUN);
  assign load_ready  = load_ready_q;
  assign prog_len    = prog_len_q;
  assign overflow    = overflow_q;
  assign fetch_oob   = fetch_oob_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Scoreboard bench for hack_rom_loader with a 16-word ROM; expectations come from a program-level model.
module tb_hack_rom_loader;

  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   pc;
  logic [DW-1:0] instruction;
  logic          cpu_reset;
  logic          load_start;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic [AW:0]   prog_len;
  logic          overflow;
  logic          fetch_oob;

  hack_rom_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instruction(instruction),
    .cpu_reset(cpu_reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .prog_len(prog_len), .overflow(overflow), .fetch_oob(fetch_oob)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          id;
    logic [15:0] val;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  // Program-level reference: what was loaded, how long it is, and the sticky flags.
  logic [15:0] ref_prog [16];
  int          ref_len = 0;
  bit          ref_ovf = 0;
  bit          ref_oob = 0;
  logic [15:0] stim_words[$];

  function automatic string nm(input int id);
    case (id)
      0: return "instruction";
      1: return "cpu_reset";
      2: return "load_ready";
      3: return "prog_len";
      4: return "overflow";
      default: return "fetch_oob";
    endcase
  endfunction

  function automatic logic [15:0] actual(input int id);
    case (id)
      0: return instruction;
      1: return 16'(cpu_reset);
      2: return 16'(load_ready);
      3: return 16'(prog_len);
      4: return 16'(overflow);
      default: return 16'(fetch_oob);
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [15:0] a;
      e = sb.pop_front();
      a = actual(e.id);
      n_chk++;
      if (e.cyc != cyc || a !== e.val) begin
        n_err++;
        $display("FAIL %s cyc=%0d got=%h expected=%h", nm(e.id), e.cyc, a, e.val);
      end
    end
  end

  task automatic check_now(input int id, input logic [15:0] v);
    logic [15:0] a;
    a = actual(id);
    n_chk++;
    if (a !== v) begin
      n_err++;
      $display("FAIL immediate %s t=%0t got=%h expected=%h", nm(id), $time, a, v);
    end
  endtask

  initial begin
    #5000000;
    n_err++;
    $display("FAIL timeout: stimulus did not finish, %0d expectations pending", sb.size());
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int id, input logic [15:0] v);
    exp_t e;
    e.cyc = cyc;
    e.id  = id;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_idle_like();
    expect_v(1, 16'd1);
    expect_v(2, 16'd0);
    expect_v(3, 16'd0);
    expect_v(4, 16'd0);
    expect_v(5, 16'd0);
    expect_v(0, 16'd0);
  endtask

  // Loads stim_words; ends in the first RUN cycle.
  task automatic load_prog(input bit mark_last, input int gap);
    int n;
    n = stim_words.size();
    load_start = 1'b1;
    load_valid = 1'b0;
    tick();
    load_start = 1'b0;
    ref_len = 0; ref_ovf = 0; ref_oob = 0;
    expect_idle_like();
    load_valid = 1'($urandom_range(0, 1));
    load_last  = 1'($urandom_range(0, 1));
    load_data  = 16'($urandom);
    tick();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          load_valid = 1'b0;
          load_data  = 16'($urandom);
          load_last  = 1'($urandom_range(0, 1));
          expect_v(2, 16'd1);
          expect_v(1, 16'd1);
          tick();
        end
      end
      load_valid = 1'b1;
      load_data  = stim_words[i];
      load_last  = mark_last && (i == n - 1);
      expect_v(2, 16'd1);
      expect_v(0, 16'd0);
      tick();
    end
    for (int i = 0; i < n; i++) ref_prog[i] = stim_words[i];
    ref_len = n;
    ref_ovf = !mark_last;
    // Release cycle; an extra offered word must not be taken.
    load_valid = 1'b1;
    load_data  = 16'($urandom);
    load_last  = 1'b0;
    expect_v(1, 16'd1);
    expect_v(2, 16'd0);
    expect_v(3, 16'(ref_len));
    expect_v(4, 16'(ref_ovf));
    expect_v(5, 16'd0);
    expect_v(0, 16'd0);
    tick();
    load_valid = 1'b0;
    expect_v(1, 16'd0);
    expect_v(2, 16'd0);
  endtask

  task automatic fetch(input logic [15:0] a);
    pc = a;
    expect_v(0, (int'(a) < ref_len) ? ref_prog[a[AW-1:0]] : 16'd0);
    expect_v(5, 16'(ref_oob));
    expect_v(1, 16'd0);
    if (int'(a) >= ref_len) ref_oob = 1;
    tick();
  endtask

  initial begin
    reset = 1'b0; pc = '0; load_start = 1'b0; load_valid = 1'b0;
    load_data = '0; load_last = 1'b0;
    tick();
    expect_idle_like();
    tick();
    reset = 1'b1;
    load_valid = 1'b1;
    expect_idle_like();
    tick();
    load_valid = 1'b0;

    // Basic load and in-range fetches
    stim_words = '{16'h0005, 16'hEC10, 16'hE308};
    load_prog(1'b1, 0);
    fetch(16'd0); fetch(16'd1); fetch(16'd2);

    // Out-of-range fetches, flag stays sticky
    fetch(16'd3); fetch(16'h8001); fetch(16'd1); fetch(16'd2);

    // Gapped reload from RUN
    load_prog(1'b1, 2);
    fetch(16'd2); fetch(16'd0); fetch(16'd1); fetch(16'h0010);

    // Overflow: 16 words without last
    stim_words.delete();
    for (int i = 0; i < 16; i++) stim_words.push_back(16'h1000 + 16'(i * 7));
    load_prog(1'b0, 0);
    fetch(16'd15); fetch(16'd0); fetch(16'd16); fetch(16'd7);

    // Single-word reload clears flags
    stim_words = '{16'h7FFF};
    load_prog(1'b1, 1);
    fetch(16'd0); fetch(16'd1); fetch(16'd0);

    // Asynchronous reset in the middle of a load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = 16'hA000 + 16'(i); load_last = 1'b0;
      tick();
    end
    load_valid = 1'b1; load_data = 16'hA002;
    reset = 1'b0;
    #1;
    check_now(1, 16'd1);
    check_now(2, 16'd0);
    check_now(3, 16'd0);
    check_now(4, 16'd0);
    check_now(5, 16'd0);
    check_now(0, 16'd0);
    ref_len = 0; ref_ovf = 0; ref_oob = 0;
    expect_idle_like();
    tick();
    reset = 1'b1;
    load_valid = 1'b0;
    expect_idle_like();
    tick();
    expect_idle_like();
    tick();

    // Randomized loads and fetches
    for (int it = 0; it < 20; it++) begin
      int  n;
      bit  ml;
      n  = $urandom_range(1, 16);
      ml = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      stim_words.delete();
      for (int i = 0; i < n; i++) stim_words.push_back(16'($urandom));
      load_prog(ml, $urandom_range(0, 2));
      for (int f = 0; f < 6; f++) begin
        if ($urandom_range(0, 3) == 0) fetch(16'($urandom));
        else fetch(16'($urandom_range(0, 17)));
      end
    end

    tick();
    @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %0d expectations expired without being checked", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hack_rom_loader.md
Name: hack_rom_loader

Overview:
- Instruction-side responder for the Hack CPU core. The core issues a fetch address on `pc` and samples `instruction` at its posedge; this block serves that fetch.
- Holds a program ROM in on-chip RAM. The ROM is filled through a valid/ready word stream from a host or boot source.
- Sequences the CPU's reset so the core runs only on a fully loaded program.

Parameters:
- ADDR_W, 15: ROM address width; depth is 2^ADDR_W words.
- DATA_W, 16: instruction word width.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- pc  in  16  fetch address from the CPU; only bits [ADDR_W-1:0] are used.
- instruction  out  DATA_W  fetched word to the CPU.
- cpu_reset  out  1  drives the CPU's synchronous active-high reset.
- load_start  in  1  single-cycle request to begin a program load.
- load_valid  in  1  load_data/load_last are valid this cycle.
- load_data  in  DATA_W  program word.
- load_last  in  1  marks the final word of the program.
- load_ready  out  1  block accepts a word this cycle.
- prog_len  out  ADDR_W+1  number of words in the loaded program.
- overflow  out  1  sticky: the load ran past ROM depth without load_last.
- fetch_oob  out  1  sticky: the CPU fetched at or beyond prog_len while in RUN.

Behaviour:
- States: IDLE, LOAD, RELEASE, RUN.
- Reset values (reset=0, asynchronous):
  - state=IDLE, cpu_reset=1, load_ready=0.
  - prog_len=0, write pointer wptr=0.
  - overflow=0, fetch_oob=0.
  - ROM contents are not cleared; they are don't-care.
- IDLE:
  - cpu_reset=1, load_ready=0, instruction=0.
  - load_start=1 -> LOAD, with wptr=0, prog_len=0, overflow=0, fetch_oob=0.
- LOAD:
  - cpu_reset=1, load_ready=1 (registered; it rises the cycle after entry).
  - A transfer occurs when load_valid && load_ready at the posedge. It writes mem[wptr]=load_data and sets wptr=wptr+1.
  - Gaps in load_valid are allowed; the block holds state across them.
  - Transfer with load_last=1: prog_len=wptr+1, load_ready=0, next state RELEASE.
  - Transfer at wptr=2^ADDR_W-1 with load_last=0: treated as last, prog_len=2^ADDR_W, overflow=1, next state RELEASE.
  - load_start is ignored while in LOAD.
- RELEASE:
  - Exactly one cycle with cpu_reset=1, so the CPU sees reset on at least one posedge after the final write.
  - Then -> RUN.
- RUN:
  - cpu_reset=0, load_ready=0.
  - instruction = mem[pc[ADDR_W-1:0]], read asynchronously (combinationally), so the word is valid within the same cycle the CPU presents pc.
  - If pc >= prog_len: instruction=0 (A-instruction @0) and fetch_oob is set at the posedge.
  - pc bits above ADDR_W-1 are ignored for the read. They do count in the prog_len comparison: the compare uses the full 16-bit pc zero-extended against prog_len.
  - load_start=1 -> LOAD (reload). cpu_reset rises at that same posedge, and wptr and the flags are cleared as in IDLE.
- Outside RUN, instruction=0.
- load_valid in any state other than LOAD: ignored, no write.
- Reset mid-LOAD or mid-RUN: immediate return to IDLE with all reset values. A partial program is discarded (prog_len=0).
- Width rules:
  - wptr is ADDR_W+1 bits internally and never exceeds 2^ADDR_W.
  - prog_len=0 is only possible in IDLE or LOAD.

Test Plan:
- Basic load: reset, then load_start, then 3 words 16'h0005, 16'hEC10, 16'hE308 back-to-back, last on the third.
  - Required: prog_len=3 and one RELEASE cycle with cpu_reset=1.
  - Then cpu_reset=0; pc=0,1,2 yields 0005, EC10, E308.
- Gapped stream: same 3 words with load_valid low for 2 cycles between each.
  - Required: identical ROM contents and prog_len=3, with no extra or duplicate writes.
- Out-of-range fetch: after the 3-word load, pc=3 and then pc=16'h8001.
  - Required: instruction=0 and fetch_oob=1 and stays 1.
  - pc=1 afterwards still returns EC10.
- Overflow (ADDR_W=4): stream 16 words, none marked last.
  - Required: 16th word accepted, overflow=1, prog_len=16, RUN entered.
  - A 17th load_valid is not accepted (load_ready=0).
- Reset mid-load: assert reset=0 asynchronously after 2 of 5 words.
  - Required: outputs take reset values without waiting for clk; state=IDLE, prog_len=0, cpu_reset=1.
- Reload during RUN: load_start in RUN, then 1 word 16'h7FFF with last.
  - Required: cpu_reset=1 at the next posedge, prog_len=1, flags cleared.
  - After RUN: pc=0 returns 7FFF; pc=1 returns 0 and sets fetch_oob.
